// File: rtl/pipe_mux_pkg.sv
// Shared constants and helpers for the pipelined mux tree.
package pipe_mux_pkg;
    localparam int MAX_NCH = 64;

    typedef logic [15:0] cnt_t;

    // Number of words left after level k has reduced its inputs.
    function automatic int lvl_words(input int nch, input int k);
        return nch >> (k + 1);
    endfunction
endpackage

// File: rtl/pipe_mux_level.sv
// One registered 2:1 reduction stage: NIN words in, NIN/2 words out.
// It also carries the valid bit and the select bits still needed by later levels.
module pipe_mux_level
    import pipe_mux_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NIN    = 4,
    parameter int SELREM = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   en,
    input  logic [NIN*WIDTH-1:0]                   d,
    input  logic [SELREM:0]                        sel,
    input  logic                                   v_in,
    output logic [lvl_words(NIN, 0)*WIDTH-1:0]     q,
    output logic [((SELREM > 0) ? SELREM : 1)-1:0] sel_q,
    output logic                                   v_q
);
    localparam int NOUT = lvl_words(NIN, 0);

    logic [NOUT*WIDTH-1:0] nxt;

    always_comb begin
        nxt = '0;
        for (int j = 0; j < NOUT; j++) begin
            nxt[j*WIDTH +: WIDTH] = sel[0] ? d[(2*j+1)*WIDTH +: WIDTH]
                                           : d[(2*j)*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q   <= '0;
            v_q <= 1'b0;
        end else if (en) begin
            q   <= nxt;
            v_q <= v_in;
        end
    end

    generate
        if (SELREM > 0) begin : g_sel
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sel_q <= '0;
                end else if (en) begin
                    sel_q <= sel[SELREM:1];
                end
            end
        end else begin : g_nosel
            // Last level: every select bit has been consumed.
            assign sel_q = '0;
        end
    endgenerate
endmodule

// File: rtl/pipe_mux_tree.sv
// Pipelined NCH:1 mux tree with valid/ready handshake and a global stall enable.
// Optional accepted-output counter is enabled by defining PIPE_MUX_CNT_EN.
module pipe_mux_tree
    import pipe_mux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          xfer_cnt
);
    // All level word vectors are packed back to back: level k input starts at
    // word 2*NCH - (2*NCH >> k). Select slices are packed the same way, with one
    // spare bit at the end for the last level's (empty) select output.
    localparam int DBUS_W = (2*NCH - 1) * WIDTH;
    localparam int SBUS_W = SELW * (SELW + 1) / 2 + 1;

    logic [DBUS_W-1:0] dbus;
    logic [SBUS_W-1:0] sbus;
    logic [SELW:0]     vbus;
    logic              en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign dbus[NCH*WIDTH-1:0] = in_data;
    assign sbus[SELW-1:0]      = in_sel;
    assign vbus[0]             = in_valid;

    generate
        for (genvar k = 0; k < SELW; k++) begin : g_lvl
            localparam int DOFF  = 2*NCH - ((2*NCH) >> k);
            localparam int DOFFN = 2*NCH - ((2*NCH) >> (k + 1));
            localparam int SOFF  = k*SELW - (k*(k-1))/2;
            localparam int SOFFN = (k+1)*SELW - ((k+1)*k)/2;
            localparam int SQW   = (SELW - k - 1 > 0) ? (SELW - k - 1) : 1;

            pipe_mux_level #(
                .WIDTH  (WIDTH),
                .NIN    (NCH >> k),
                .SELREM (SELW - k - 1)
            ) u_level (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .d     (dbus[DOFF*WIDTH +: (NCH >> k)*WIDTH]),
                .sel   (sbus[SOFF +: SELW - k]),
                .v_in  (vbus[k]),
                .q     (dbus[DOFFN*WIDTH +: lvl_words(NCH, k)*WIDTH]),
                .sel_q (sbus[SOFFN +: SQW]),
                .v_q   (vbus[k+1])
            );
        end
    endgenerate

    assign out_data  = dbus[(2*NCH - 2)*WIDTH +: WIDTH];
    assign out_valid = vbus[SELW];

`ifdef PIPE_MUX_CNT_EN
    cnt_t cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (out_valid && out_ready) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign xfer_cnt = cnt;
`else
    assign xfer_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_pipe_mux_tree.sv
// Directed bench: a 4x4 instance driven from a per-cycle vector table plus
// reset sequences, and a 16x32 instance streamed with random selects.
module tb_pipe_mux_tree;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Narrow instance (default parameters)
    logic [15:0] n_data;
    logic [1:0]  n_sel;
    logic        n_valid, n_iready, n_ovalid, n_ready;
    logic [3:0]  n_odata;
    logic [15:0] n_cnt;

    pipe_mux_tree u_n (
        .clk(clk), .rst_n(rst_n), .in_data(n_data), .in_sel(n_sel),
        .in_valid(n_valid), .in_ready(n_iready), .out_data(n_odata),
        .out_valid(n_ovalid), .out_ready(n_ready), .xfer_cnt(n_cnt)
    );

    // Wide instance
    logic [511:0] w_data;
    logic [3:0]   w_sel;
    logic         w_valid, w_iready, w_ovalid, w_ready;
    logic [31:0]  w_odata;
    logic [15:0]  w_cnt;

    pipe_mux_tree #(.WIDTH(32), .NCH(16)) u_w (
        .clk(clk), .rst_n(rst_n), .in_data(w_data), .in_sel(w_sel),
        .in_valid(w_valid), .in_ready(w_iready), .out_data(w_odata),
        .out_valid(w_ovalid), .out_ready(w_ready), .xfer_cnt(w_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] sel;
        logic       valid;
        logic       rdy;
        logic       e_valid;
        logic [3:0] e_data;
        logic       e_iready;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [1:0] s, input logic v, input logic r,
                                input logic ev, input logic [3:0] ed, input logic ei);
        vec_t t;
        t.sel = s; t.valid = v; t.rdy = r; t.e_valid = ev; t.e_data = ed; t.e_iready = ei;
        return t;
    endfunction

    logic [31:0] wq[$];
    logic [31:0] exp_w;
    int          done_w;

    initial begin
        // basic select, one beat per cycle, completions overlapping accepts
        vt.push_back(mk(2'd0, 1, 1, 0, 4'h0, 1));
        vt.push_back(mk(2'd1, 1, 1, 1, 4'hA, 1));
        vt.push_back(mk(2'd2, 1, 1, 1, 4'hB, 1));
        vt.push_back(mk(2'd3, 1, 1, 1, 4'hC, 1));
        vt.push_back(mk(2'd0, 0, 1, 1, 4'hD, 1));
        vt.push_back(mk(2'd0, 0, 1, 0, 4'h0, 1));
        // backpressure: D held for three stalled cycles, then D,C,B
        vt.push_back(mk(2'd3, 1, 1, 0, 4'h0, 1));
        vt.push_back(mk(2'd2, 1, 1, 1, 4'hD, 1));
        vt.push_back(mk(2'd1, 1, 0, 1, 4'hD, 0));
        vt.push_back(mk(2'd1, 1, 0, 1, 4'hD, 0));
        vt.push_back(mk(2'd1, 1, 0, 1, 4'hD, 0));
        vt.push_back(mk(2'd1, 1, 1, 1, 4'hC, 1));
        vt.push_back(mk(2'd0, 0, 1, 1, 4'hB, 1));
        vt.push_back(mk(2'd0, 0, 1, 0, 4'h0, 1));
        // select change in flight
        vt.push_back(mk(2'd1, 1, 1, 0, 4'h0, 1));
        vt.push_back(mk(2'd2, 0, 1, 1, 4'hB, 1));
        vt.push_back(mk(2'd2, 0, 1, 0, 4'h0, 1));
        vt.push_back(mk(2'd2, 0, 1, 0, 4'h0, 1));
        // out_ready=0 on an empty pipe still accepts
        vt.push_back(mk(2'd0, 1, 0, 0, 4'h0, 1));
        vt.push_back(mk(2'd0, 0, 0, 1, 4'hA, 0));
        vt.push_back(mk(2'd0, 0, 1, 0, 4'h0, 1));

        n_data  = 16'hDCBA;
        for (int c = 0; c < 16; c++) w_data[c*32 +: 32] = 32'hC0DE_0000 + c;
        n_sel   = 2'd0; n_valid = 1'b1; n_ready = 1'b1;
        w_sel   = 4'd0; w_valid = 1'b1; w_ready = 1'b1;

        // reset held for two clocks with in_valid asserted
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, n_ovalid}, 32'd0);
        chk("rst_out_data",  {28'd0, n_odata},  32'd0);
        chk("rst_xfer_cnt",  {16'd0, n_cnt},    32'd0);
        chk("rst_w_valid",   {31'd0, w_ovalid}, 32'd0);
        chk("rst_w_data",    w_odata,           32'd0);
        @(negedge clk);
        rst_n = 1'b1; n_valid = 1'b0; w_valid = 1'b0;
        #1;
        chk("rst_in_ready",  {31'd0, n_iready}, 32'd1);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            n_sel = vt[i].sel; n_valid = vt[i].valid; n_ready = vt[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), {31'd0, n_ovalid}, {31'd0, vt[i].e_valid});
            chk($sformatf("vec%0d_in_ready", i),  {31'd0, n_iready}, {31'd0, vt[i].e_iready});
            if (vt[i].e_valid)
                chk($sformatf("vec%0d_out_data", i), {28'd0, n_odata}, {28'd0, vt[i].e_data});
        end

        // reset mid-stream: beat A in flight, beat B presented during reset
        @(negedge clk);
        n_sel = 2'd0; n_valid = 1'b1; n_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; n_sel = 2'd1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", {31'd0, n_ovalid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; n_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("midrst_drain%0d", i), {31'd0, n_ovalid}, 32'd0);
        end

        // wide stream: 70000 random selects, latency 4, no stalls
        done_w = 0;
        for (int n = 0; n < 70003; n++) begin
            @(negedge clk);
            if (n < 70000) begin
                w_sel   = 4'($urandom_range(0, 15));
                w_valid = 1'b1;
                wq.push_back(32'hC0DE_0000 + {28'd0, w_sel});
            end else begin
                w_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (n >= 3) begin
                exp_w = wq.pop_front();
                chk("wide_out_valid", {31'd0, w_ovalid}, 32'd1);
                chk("wide_out_data", w_odata, exp_w);
                done_w++;
            end else begin
                chk("wide_lat_valid", {31'd0, w_ovalid}, 32'd0);
            end
        end
        @(negedge clk);
        #1;
        chk("wide_done_count", done_w, 32'd70000);
        @(posedge clk);
        #1;
        chk("wide_drained", {31'd0, w_ovalid}, 32'd0);
`ifdef PIPE_MUX_CNT_EN
        chk("wide_xfer_cnt", {16'd0, w_cnt}, 32'd4464);
`else
        chk("wide_xfer_cnt", {16'd0, w_cnt}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
